serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 14 +
 rtl/fa_dataflow.sv | 15 +
 rtl/serial_adder.sv | 99 +++++++++
 tb/tb_serial_adder.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding and default width.
// No logic, no latency.
// No flow control; consumed by serial_adder.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fa_dataflow.sv
// 1-bit full adder, dataflow form; the combinational bit slice of the serial adder.
// Latency: purely combinational, zero cycles.
// No flow control.
module fa_dataflow (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: {co,s} = a + b + ci, one bit per clock through a single full adder.
// Latency: WIDTH cycles from accepted start to done; one operation per WIDTH+2 cycles.
// No backpressure: start is only sampled in IDLE; requests in RUN/DONE are dropped.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last_bit;
  logic             fa_s;
  logic             fa_co;

  // The counter indexes the bit being processed; it stops at WIDTH-1.
  assign last_bit = (cnt == CW'(WIDTH - 1));

  fa_dataflow u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // Next-state logic: IDLE -> RUN on start, RUN -> DONE after the MSB, DONE -> IDLE always.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; busy/done are registered decodes of the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == RUN);
      done  <= (state_nxt == DONE);
    end
  end

  // Datapath: load operands on accept, then shift one bit per cycle through the full adder.
  // Sum bits enter at the MSB so after WIDTH shifts bit 0 of the result sits at s[0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      s     <= '0;
      co    <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        a_sh  <= a;
        b_sh  <= b;
        carry <= ci;
        cnt   <= '0;
        s     <= '0;
      end
    end else if (state == RUN) begin
      a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
      s     <= {fa_s, s[WIDTH-1:1]};
      carry <= fa_co;
      if (last_bit) begin
        co <= fa_co;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  logic       clk;
  logic       rst_n;

  logic       start8;
  logic [7:0] a8, b8;
  logic       ci8;
  logic       busy8, done8, co8;
  logic [7:0] s8;

  logic       start4;
  logic [3:0] a4, b4;
  logic       ci4;
  logic       busy4, done4, co4;
  logic [3:0] s4;

  int checks;
  int failures;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .ci    (ci8),
    .busy  (busy8),
    .done  (done8),
    .s     (s8),
    .co    (co8)
  );

  serial_adder #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .ci    (ci4),
    .busy  (busy4),
    .done  (done4),
    .s     (s4),
    .co    (co4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; ci4 = 1'b0;
    tick(); tick();
    checks++;
    if ({busy8, done8, co8, s8} !== 11'h000) begin
      failures++;
      $display("FAIL reset_w8: busy=%b done=%b co=%b s=%h expected all zero", busy8, done8, co8, s8);
    end
    checks++;
    if ({busy4, done4, co4, s4} !== 7'h00) begin
      failures++;
      $display("FAIL reset_w4: busy=%b done=%b co=%b s=%h expected all zero", busy4, done4, co4, s4);
    end
    rst_n = 1'b1;
    tick();
  endtask

  // Caller must be at a sample point with the DUT in IDLE.
  task automatic do_op8(input logic [7:0] ta, input logic [7:0] tb, input logic tci,
                        input logic [7:0] es, input logic eco, input string nm);
    int bad_busy;
    a8 = ta; b8 = tb; ci8 = tci; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    bad_busy = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy8 !== 1'b1 || done8 !== 1'b0) bad_busy++;
      tick();
    end
    checks++;
    if (bad_busy != 0) begin
      failures++;
      $display("FAIL %s_busy: %0d of 8 run cycles had wrong busy/done", nm, bad_busy);
    end
    checks++;
    if (done8 !== 1'b1 || busy8 !== 1'b0) begin
      failures++;
      $display("FAIL %s_done: done=%b busy=%b expected done=1 busy=0", nm, done8, busy8);
    end
    checks++;
    if ({co8, s8} !== {eco, es}) begin
      failures++;
      $display("FAIL %s_sum: co=%b s=%h expected co=%b s=%h", nm, co8, s8, eco, es);
    end
    tick();
    checks++;
    if (done8 !== 1'b0 || busy8 !== 1'b0 || {co8, s8} !== {eco, es}) begin
      failures++;
      $display("FAIL %s_idle: done=%b busy=%b co=%b s=%h expected 0 0 %b %h",
               nm, done8, busy8, co8, s8, eco, es);
    end
  endtask

  task automatic test_basic_sums();
    do_op8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "zero");
    do_op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ff_plus_1");
    do_op8(8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1, "5a_a5_ci");
    do_op8(8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0, "3c_0f_ci");
  endtask

  task automatic test_ignored_start();
    int n_done;
    int busy_after;
    a8 = 8'h12; b8 = 8'h34; ci8 = 1'b0; start8 = 1'b1;
    tick();                                // accept edge T0
    start8 = 1'b0;
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1; start8 = 1'b1; end
      if (i == 4) start8 = 1'b0;
      if (done8 === 1'b1) n_done++;
      tick();
    end
    // now in DONE; pulse start with other operands, it must be ignored
    checks++;
    if (done8 !== 1'b1 || {co8, s8} !== 9'h046) begin
      failures++;
      $display("FAIL ignore_result: done=%b co=%b s=%h expected done=1 co=0 s=46", done8, co8, s8);
    end
    a8 = 8'h77; b8 = 8'h99; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    busy_after = 0;
    for (int i = 0; i < 12; i++) begin
      if (done8 === 1'b1) n_done++;
      if (busy8 === 1'b1) busy_after++;
      tick();
    end
    checks++;
    if (n_done != 0 || busy_after != 0) begin
      failures++;
      $display("FAIL ignore_extra: extra_done=%0d busy_cycles=%0d expected 0 0", n_done, busy_after);
    end
    checks++;
    if ({co8, s8} !== 9'h046) begin
      failures++;
      $display("FAIL ignore_hold: co=%b s=%h expected co=0 s=46", co8, s8);
    end
  endtask

  task automatic test_reset_mid_run();
    int n_done;
    do_op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "pre_reset");
    a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();                // three bits processed, partial sum nonzero
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy8, done8, co8, s8} !== 11'h000) begin
      failures++;
      $display("FAIL midrun_reset: busy=%b done=%b co=%b s=%h expected all zero", busy8, done8, co8, s8);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      if (done8 === 1'b1 || busy8 === 1'b1) n_done++;
      tick();
    end
    checks++;
    if (n_done != 0) begin
      failures++;
      $display("FAIL midrun_no_done: activity_cycles=%0d expected 0", n_done);
    end
    do_op8(8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0, "post_reset");
  endtask

  task automatic test_back_to_back();
    int done_idx[$];
    int bad;
    a8 = 8'h01; b8 = 8'h01; ci8 = 1'b0; start8 = 1'b1;
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (done8 === 1'b1) begin
        done_idx.push_back(i);
        if ({co8, s8} !== 9'h002) bad++;
      end
      // one cycle after done: IDLE, result held
      if (done_idx.size() > 0 && i == done_idx[$] + 1) begin
        if ({co8, s8} !== 9'h002 || busy8 !== 1'b0) bad++;
      end
      // two cycles after done: new operation accepted, s cleared
      if (done_idx.size() > 0 && i == done_idx[$] + 2) begin
        if (s8 !== 8'h00 || busy8 !== 1'b1) bad++;
      end
    end
    start8 = 1'b0;
    checks++;
    if (done_idx.size() != 3) begin
      failures++;
      $display("FAIL b2b_count: dones=%0d expected 3", done_idx.size());
    end else begin
      checks++;
      if (done_idx[0] != 8 || done_idx[1] != 18 || done_idx[2] != 28) begin
        failures++;
        $display("FAIL b2b_spacing: done at %0d %0d %0d expected 8 18 28",
                 done_idx[0], done_idx[1], done_idx[2]);
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL b2b_values: %0d bad samples of s/co/busy around done", bad);
    end
    for (int i = 0; i < 12 && (busy8 === 1'b1 || done8 === 1'b1); i++) tick();
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain: busy=%b done=%b expected 0 0", busy8, done8);
    end
    tick();
  endtask

  task automatic test_exhaustive_w4();
    int bad_timing;
    int sum;
    logic [8:0] v;
    bad_timing = 0;
    start4 = 1'b1;
    for (int idx = 0; idx < 512; idx++) begin
      v = 9'(idx);
      a4 = v[8:5]; b4 = v[4:1]; ci4 = v[0];
      tick();                              // accept edge
      if (busy4 !== 1'b1) bad_timing++;
      repeat (3) begin
        tick();
        if (done4 !== 1'b0) bad_timing++;
      end
      tick();                              // T0+4: done
      if (done4 !== 1'b1 || busy4 !== 1'b0) bad_timing++;
      sum = int'(v[8:5]) + int'(v[4:1]) + int'(v[0]);
      checks++;
      if ({co4, s4} !== 5'(sum)) begin
        failures++;
        $display("FAIL exh_sum a=%h b=%h ci=%b: got %h expected %h", v[8:5], v[4:1], v[0], {co4, s4}, 5'(sum));
      end
      tick();                              // T0+5: IDLE
      if (done4 !== 1'b0 || busy4 !== 1'b0) bad_timing++;
    end
    start4 = 1'b0;
    checks++;
    if (bad_timing != 0) begin
      failures++;
      $display("FAIL exh_timing: %0d samples with wrong busy/done", bad_timing);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic_sums();
    test_ignored_start();
    test_reset_mid_run();
    test_back_to_back();
    test_exhaustive_w4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
